conv_enc_out_sched: RTL and testbench

- Drains the three rate-1/3 output sub-block FIFOs of the parallel convolutional encoder after each code block.
- Serializes the byte-wide sub-block streams into one byte stream with a downstream valid/ready handshake. Per FIFO word the order is d0, d1, d2.
- Drives the shared `rdreq_subblock` line and tags every byte with its stream id and block delimiters.
- Sits between the encoder's FIFO outputs and the rate-matching / interleaver stage.

---
 rtl/conv_enc_pkg.sv | 22 ++
 rtl/conv_sched_word_cnt.sv | 32 +++
 rtl/conv_enc_out_sched.sv | 144 ++++++++++++++
 tb/tb_conv_enc_out_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_enc_pkg.sv
// Shared definitions for the convolutional-encoder output path:
// scheduler state encoding, block sizes in FIFO words, and stream ids.
package conv_enc_pkg;

   localparam int SHORT_WORDS = 132;   // 1056-bit block
   localparam int LONG_WORDS  = 768;   // 6144-bit block
   localparam int CNT_W       = 10;    // holds LONG_WORDS-1

   localparam logic [1:0] SID_D0 = 2'd0;
   localparam logic [1:0] SID_D1 = 2'd1;
   localparam logic [1:0] SID_D2 = 2'd2;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CAP  = 3'd2,
      E0   = 3'd3,
      E1   = 3'd4,
      E2   = 3'd5
   } sched_state_t;

endpackage

// File: rtl/conv_sched_word_cnt.sv
// Loadable word up-counter. A load clears the count and latches the index of
// the last word (N-1); tc flags that the current word is the last one.
module conv_sched_word_cnt #(
   parameter int CNT_W = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] last_in,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             tc
);

   logic [CNT_W-1:0] last_q;

   // load wins over inc; the block length is fixed once loaded
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count  <= '0;
         last_q <= '0;
      end else if (load) begin
         count  <= '0;
         last_q <= last_in;
      end else if (inc) begin
         count  <= count + 1'b1;
      end
   end

   assign tc = (count == last_q);

endmodule

// File: rtl/conv_enc_out_sched.sv
// Output scheduler for the rate-1/3 encoder: after each code block, reads the
// three sub-block FIFOs one word at a time and serializes d0, d1, d2 onto a
// byte stream with valid/ready, stream id and sop/eop tags.
// Optional: define CONV_SCHED_STATS_EN to add blocks_done / bytes_sent counters.
module conv_enc_out_sched
   import conv_enc_pkg::*;
#(
   parameter int SHORT_WORDS = conv_enc_pkg::SHORT_WORDS,
   parameter int LONG_WORDS  = conv_enc_pkg::LONG_WORDS,
   parameter int CNT_W       = conv_enc_pkg::CNT_W
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        computation_done,
   input  logic        length_out,
   input  logic [7:0]  q0,
   input  logic [7:0]  q1,
   input  logic [7:0]  q2,
   output logic        rdreq_subblock,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [1:0]  out_stream_id,
   output logic        out_sop,
   output logic        out_eop,
   output logic        busy,
   output logic        err_overrun
`ifdef CONV_SCHED_STATS_EN
   ,
   output logic [15:0] blocks_done,
   output logic [23:0] bytes_sent
`endif
);

   localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_WORDS - 1);
   localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_WORDS - 1);

   sched_state_t     state, next_state;
   logic [2:0][7:0]  hold;
   logic             pending, pend_len;
   logic             len_sel, cnt_load, cnt_inc, tc;
   logic [CNT_W-1:0] count;

   // a pending request takes priority over the live select in IDLE
   assign len_sel  = pending ? pend_len : length_out;
   assign cnt_load = (state == IDLE) && (computation_done || pending);
   assign cnt_inc  = (state == E2) && out_ready && !tc;
   assign busy     = (state != IDLE);

   conv_sched_word_cnt #(.CNT_W(CNT_W)) u_word_cnt (
      .clk     (clk),
      .reset   (reset),
      .load    (cnt_load),
      .last_in (len_sel ? LONG_LAST : SHORT_LAST),
      .inc     (cnt_inc),
      .count   (count),
      .tc      (tc)
   );

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // next state and output mux; outputs only change with state/hold, so they
   // stay stable across a stall
   always_comb begin
      next_state     = state;
      rdreq_subblock = 1'b0;
      out_valid      = 1'b0;
      out_data       = '0;
      out_stream_id  = SID_D0;
      out_sop        = 1'b0;
      out_eop        = 1'b0;
      case (state)
         IDLE: if (computation_done || pending) next_state = RD;
         RD: begin
            rdreq_subblock = 1'b1;
            next_state     = CAP;
         end
         CAP: next_state = E0;
         E0: begin
            out_valid     = 1'b1;
            out_data      = hold[0];
            out_stream_id = SID_D0;
            out_sop       = (count == '0);
            if (out_ready) next_state = E1;
         end
         E1: begin
            out_valid     = 1'b1;
            out_data      = hold[1];
            out_stream_id = SID_D1;
            if (out_ready) next_state = E2;
         end
         E2: begin
            out_valid     = 1'b1;
            out_data      = hold[2];
            out_stream_id = SID_D2;
            out_eop       = tc;
            if (out_ready) next_state = tc ? IDLE : RD;
         end
         default: next_state = IDLE;
      endcase
   end

   // FIFO data arrives the cycle after RD, i.e. while in CAP
   always_ff @(posedge clk or posedge reset) begin
      if (reset)             hold <= '0;
      else if (state == CAP) hold <= {q2, q1, q0};
   end

   // one request can wait behind the running block; a further one is lost
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending     <= 1'b0;
         pend_len    <= 1'b0;
         err_overrun <= 1'b0;
      end else if (state == IDLE) begin
         pending <= 1'b0;
      end else if (computation_done) begin
         if (!pending) begin
            pending  <= 1'b1;
            pend_len <= length_out;
         end else begin
            err_overrun <= 1'b1;
         end
      end
   end

`ifdef CONV_SCHED_STATS_EN
   // free-running, wrapping traffic counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blocks_done <= '0;
         bytes_sent  <= '0;
      end else if (out_valid && out_ready) begin
         bytes_sent <= bytes_sent + 1'b1;
         if (state == E2 && tc) blocks_done <= blocks_done + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_conv_enc_out_sched.sv
// Bench for conv_enc_out_sched: a block-level reference model (FIFO contents
// and expected byte stream kept as queues) checked on every falling edge,
// plus directed literal checks on latency, counts and corner cases.
module tb_conv_enc_out_sched;
   import conv_enc_pkg::*;

   logic       clk = 1'b0, reset = 1'b1;
   logic       computation_done = 1'b0, length_out = 1'b0, out_ready = 1'b0;
   logic [7:0] q0 = '0, q1 = '0, q2 = '0;
   logic       rdreq_subblock, out_valid, out_sop, out_eop, busy, err_overrun;
   logic [7:0] out_data;
   logic [1:0] out_stream_id;
`ifdef CONV_SCHED_STATS_EN
   logic [15:0] blocks_done;
   logic [23:0] bytes_sent;
`endif

   conv_enc_out_sched dut (
      .clk(clk), .reset(reset), .computation_done(computation_done),
      .length_out(length_out), .q0(q0), .q1(q1), .q2(q2),
      .rdreq_subblock(rdreq_subblock), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_stream_id(out_stream_id), .out_sop(out_sop),
      .out_eop(out_eop), .busy(busy), .err_overrun(err_overrun)
`ifdef CONV_SCHED_STATS_EN
      , .blocks_done(blocks_done), .bytes_sent(bytes_sent)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic [1:0] sid;
      logic       sop;
      logic       eop;
   } exp_t;

   exp_t        exp_q[$];
   logic [23:0] fifo_q[$];
   int total = 0, bad = 0, cyc = 0;
   bit m_active = 0, m_pend = 0, m_pend_len = 0, m_err = 0, rnd_ready = 0;
   int cur_rd = 0, cur_n = 0, byte_cnt = 0, blk_no = 0, blocks_fin = 0;
   int last_rd = 0, last_bytes = 0, last_n = 0;
   int pulse_cyc = 0, sop_cyc = -1, eop_cyc = 0;
   logic [7:0] first_b[3];
   logic [7:0] last_b;

   task automatic chk(string name, int act, int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // accepted block: fill the FIFO model and the expected byte stream
   task automatic start_blk(bit len);
      int   n;
      int   salt;
      exp_t e;
      n    = len ? LONG_WORDS : SHORT_WORDS;
      salt = blk_no * 3;
      for (int k = 0; k < n; k++) begin
         logic [7:0] a, b, c;
         a = 8'(k + salt);
         b = 8'(8'h40 + k + salt);
         c = 8'(8'h80 + k + salt);
         fifo_q.push_back({c, b, a});
         e.d = a; e.sid = SID_D0; e.sop = (k == 0); e.eop = 1'b0; exp_q.push_back(e);
         e.d = b; e.sid = SID_D1; e.sop = 1'b0;     e.eop = 1'b0; exp_q.push_back(e);
         e.d = c; e.sid = SID_D2; e.sop = 1'b0;     e.eop = (k == n - 1); exp_q.push_back(e);
      end
      blk_no++;
      m_active = 1; cur_rd = 0; cur_n = n; byte_cnt = 0; sop_cyc = -1;
   endtask

   // FIFO model, normal mode: data shows up the cycle after the read
   always @(posedge clk) begin
      if (rdreq_subblock && fifo_q.size() > 0) {q2, q1, q0} <= fifo_q.pop_front();
   end

   // compare current cycle against the model, then advance the model
   always @(negedge clk) begin
      exp_t e;
      bit   fin;
      cyc++;
      fin = 0;
      if (reset) begin
         exp_q.delete(); fifo_q.delete();
         m_active = 0; m_pend = 0; m_err = 0;
      end else begin
         chk("busy", busy, m_active);
         chk("err_overrun", err_overrun, m_err);
         if (!m_active) chk("rdreq_when_idle", rdreq_subblock, 0);
         if (rdreq_subblock) begin
            cur_rd++;
            chk("reads_within_block", int'(cur_rd <= cur_n), 1);
         end
         if (out_valid) begin
            if (exp_q.size() == 0) chk("valid_with_no_expected_byte", exp_q.size(), 1);
            else begin
               e = exp_q[0];
               chk("out_data", out_data, e.d);
               chk("out_stream_id", out_stream_id, e.sid);
               chk("out_sop", out_sop, e.sop);
               chk("out_eop", out_eop, e.eop);
               if (e.sop && sop_cyc < 0) sop_cyc = cyc;
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  if (byte_cnt < 3) first_b[byte_cnt] = out_data;
                  last_b = out_data;
                  byte_cnt++;
                  if (e.eop) begin
                     fin = 1; eop_cyc = cyc; blocks_fin++;
                     last_rd = cur_rd; last_bytes = byte_cnt; last_n = cur_n;
                  end
               end
            end
         end else begin
            chk("sop_without_valid", out_sop, 0);
            chk("eop_without_valid", out_eop, 0);
         end
         if (computation_done) pulse_cyc = cyc;
         if (!m_active) begin
            if (m_pend) begin m_pend = 0; start_blk(m_pend_len); end
            else if (computation_done) start_blk(length_out);
         end else if (computation_done) begin
            if (!m_pend) begin m_pend = 1; m_pend_len = length_out; end
            else m_err = 1;
         end
         if (fin) m_active = 0;
      end
   end

   // downstream ready: always high or ~50% random
   initial forever begin
      @(posedge clk); #1;
      out_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic pulse(bit len);
      @(posedge clk); #1;
      computation_done = 1'b1; length_out = len;
      @(posedge clk); #1;
      computation_done = 1'b0;
   endtask

   task automatic wait_idle(int budget, string tag);
      int n = 0;
      while ((m_active || m_pend || exp_q.size() != 0) && n < budget) begin
         @(posedge clk); n++;
      end
      chk({"drain_", tag}, int'(n < budget), 1);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1; reset = 1'b1;
      @(posedge clk); @(posedge clk); #1; reset = 1'b0;
   endtask

   initial begin
      int n, b0;
      // reset state
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rdreq", rdreq_subblock, 0);
      chk("rst_err", err_overrun, 0);
      chk("rst_data", out_data, 0);
      chk("rst_sop_eop", {out_sop, out_eop}, 0);
      @(posedge clk); @(posedge clk); #1; reset = 1'b0;

      // short block, ready held high: latency, throughput, order
      rnd_ready = 0;
      pulse(0);
      wait_idle(2000, "short");
      chk("short_first_valid_latency", sop_cyc - pulse_cyc, 3);
      chk("short_eop_cycle", eop_cyc - pulse_cyc, 3 + 5 * 131 + 2);
      chk("short_bytes", last_bytes, 396);
      chk("short_reads", last_rd, 132);
      chk("short_byte0", first_b[0], 8'h00);
      chk("short_byte1", first_b[1], 8'h40);
      chk("short_byte2", first_b[2], 8'h80);
      chk("short_last_byte", last_b, 8'h03);

      // long block under random backpressure
      rnd_ready = 1;
      pulse(1);
      wait_idle(30000, "long");
      chk("long_bytes", last_bytes, 2304);
      chk("long_reads", last_rd, 768);

      // back-to-back: second pulse pends, third is dropped
      rnd_ready = 0;
      b0 = blocks_fin;
      pulse(0);
      repeat (30) @(posedge clk);
      pulse(1);
      repeat (30) @(posedge clk);
      pulse(0);
      wait_idle(10000, "b2b");
      chk("b2b_overrun", err_overrun, 1);
      chk("b2b_blocks", blocks_fin - b0, 2);
      chk("b2b_second_len", last_n, 768);
      chk("b2b_second_bytes", last_bytes, 2304);

      // pulse coincident with the final handshake
      do_reset();
      chk("overrun_cleared", err_overrun, 0);
      b0 = blocks_fin;
      pulse(0);
      n = 0;
      while (!out_eop && n < 2000) begin @(posedge clk); #1; n++; end
      chk("coinc_eop_seen", int'(n < 2000), 1);
      computation_done = 1'b1; length_out = 1'b0;
      @(posedge clk); #1; computation_done = 1'b0;
      wait_idle(2000, "coinc");
      // pulse cycle is E2, then IDLE, RD, CAP, E0
      chk("coinc_sop_latency", sop_cyc - pulse_cyc, 4);
      chk("coinc_no_overrun", err_overrun, 0);
      chk("coinc_blocks", blocks_fin - b0, 2);

      // asynchronous reset in E1 of word 50
      rnd_ready = 1;
      pulse(0);
      n = 0;
      while (!(out_valid && out_stream_id == SID_D1 && cur_rd == 51) && n < 5000) begin
         @(posedge clk); #1; n++;
      end
      chk("mid_reset_reached_word50", int'(n < 5000), 1);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_data", out_data, 0);
      chk("async_rst_sid", out_stream_id, 0);
      chk("async_rst_rdreq", rdreq_subblock, 0);
      @(posedge clk); #1; reset = 1'b0;
      pulse(0);
      wait_idle(5000, "restart");
      chk("restart_bytes", last_bytes, 396);
      chk("restart_reads", last_rd, 132);

      // random pulses and backpressure
      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(0, 600)) @(posedge clk);
         @(posedge clk); #1;
         if (m_pend && !m_active) begin @(posedge clk); #1; end
         computation_done = 1'b1;
         length_out = ($urandom_range(0, 7) == 0);
         @(posedge clk); #1; computation_done = 1'b0;
      end
      wait_idle(40000, "random");

`ifdef CONV_SCHED_STATS_EN
      do_reset();
      rnd_ready = 0;
      for (int i = 0; i < 3; i++) begin
         pulse(0);
         wait_idle(2000, "stats");
      end
      chk("stats_blocks_done", blocks_done, 3);
      chk("stats_bytes_sent", bytes_sent, 1188);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
